// File: rtl/garage_input_conditioner.sv
// garage_input_conditioner
// Synchronises and debounces the wall button and both door limit switches,
// and turns each accepted button press into a single-cycle Activate pulse
// followed by a hold-off window. A press is discarded while both limit
// switches read active, since that can only be a wiring fault.
//
// Channel packing used throughout: bit 0 = button, bit 1 = top limit,
// bit 2 = bottom limit.
module garage_input_conditioner #(
  parameter int DEB_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_RAW,
  input  logic UP_SW_RAW,
  input  logic DN_SW_RAW,
  output logic Activate,
  output logic Up_MAX,
  output logic Dn_MAX,
  output logic SW_FAULT
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  // Hold-off is left on the cycle the counter steps onto HOLDOFF_CYCLES-1,
  // so Activate rising edges are spaced HOLDOFF_CYCLES+1 cycles at best.
  localparam logic [HW-1:0] HOLD_EXIT =
    (HOLDOFF_CYCLES > 1) ? HW'(HOLDOFF_CYCLES - 2) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [2:0]          raw;
  logic [2:0]          s1_q, s1_d;
  logic [2:0]          s2_q, s2_d;
  logic [2:0]          stable_q, stable_d;
  logic [2:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
  // Button stable level delayed by one cycle, used for edge detection.
  logic                btn_dly_q, btn_dly_d;

  state_t              state_q;
  logic [HW-1:0]       hold_cnt_q;
  logic                act_q;

  logic                rise;
  logic                fault;

  assign raw = {DN_SW_RAW, UP_SW_RAW, BTN_RAW};

  // Two-flop synchronisers and edge-detect delay.
  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    btn_dly_d = stable_q[0];
  end

  // Debounce: a new level is accepted only after DEB_CYCLES consecutive
  // synchronised samples differ from the current stable level.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (s2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_LAST) begin
        stable_d[i]  = s2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
      end
    end
  end

  // Conditioning registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_q      <= '0;
      s2_q      <= '0;
      stable_q  <= '0;
      deb_cnt_q <= '0;
      btn_dly_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      btn_dly_q <= btn_dly_d;
    end
  end

  assign rise  = stable_q[0] & ~btn_dly_q;
  assign fault = stable_q[1] & stable_q[2];

  // Press FSM: IDLE accepts a clean rise, FIRE lasts one cycle, HOLDOFF
  // swallows further rises (they are not queued). Activate mirrors FIRE.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      act_q      <= 1'b0;
    end else begin
      act_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise && !fault) begin
            state_q <= FIRE;
            act_q   <= 1'b1;
          end
        end
        FIRE: begin
          state_q    <= HOLDOFF;
          hold_cnt_q <= '0;
        end
        HOLDOFF: begin
          hold_cnt_q <= hold_cnt_q + HW'(1);
          if (hold_cnt_q == HOLD_EXIT) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Activate = act_q;
  assign Up_MAX   = stable_q[1];
  assign Dn_MAX   = stable_q[2];
  assign SW_FAULT = fault;

endmodule

// File: doc/garage_input_conditioner.md
# garage_input_conditioner

Front-end conditioning stage for the garage door controller. It synchronises and debounces the raw wall button and the two door limit switches, and drives the controller's `Activate`, `Up_MAX` and `Dn_MAX` inputs. `Activate` is a clean single-cycle pulse, followed by a hold-off window. A pulse is blocked while both limit switches read active, which is a wiring fault.

## Interface

Parameters:
- `DEB_CYCLES`, default 16: consecutive differing synchronised samples needed to accept a new level. Legal range ≥ 2.
- `HOLDOFF_CYCLES`, default 64: cycles after an `Activate` pulse during which new presses are ignored. Legal range ≥ 1.

Ports:
- `CLK`  in  1  system clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `BTN_RAW`  in  1  wall button, asynchronous, 1 = pressed.
- `UP_SW_RAW`  in  1  top limit switch, asynchronous, 1 = door fully open.
- `DN_SW_RAW`  in  1  bottom limit switch, asynchronous, 1 = door fully closed.
- `Activate`  out  1  single-cycle press pulse, registered.
- `Up_MAX`  out  1  debounced top limit, registered.
- `Dn_MAX`  out  1  debounced bottom limit, registered.
- `SW_FAULT`  out  1  `Up_MAX & Dn_MAX`, derived from registers only.

## Operation

- **Reset.** Reset is asynchronous and active-low on `RST`, with clock `CLK`. Every flop clears to 0: synchronisers, stable levels, debounce counters, hold-off counter and FSM (state `IDLE`). All outputs are 0 during reset.
- **Synchronisers.** Each raw input passes through a 2-flop synchroniser: `s1`, then `s2`.
- **Debouncer** (one per channel: `stable` register plus a counter of width `$clog2(DEB_CYCLES)`):
  - If `s2 == stable`: counter ← 0.
  - If `s2 != stable` and counter < `DEB_CYCLES-1`: counter increments.
  - If `s2 != stable` and counter == `DEB_CYCLES-1`: `stable` ← `s2`, counter ← 0.
  - A run of differing samples shorter than `DEB_CYCLES` leaves `stable` unchanged.
- **Outputs from debouncers.** `Up_MAX` and `Dn_MAX` are the stable registers of the top and bottom switch channels.
- **Button edge.** `btn_d` holds the button stable level from the previous cycle. `rise = btn_stable & ~btn_d`.
- **Button FSM** (3 states):
  - `IDLE`: if `rise & ~SW_FAULT`, go to `FIRE`. A rise while `SW_FAULT` = 1 is discarded and the FSM stays in `IDLE`.
  - `FIRE`: go to `HOLDOFF` unconditionally and clear the hold-off counter.
  - `HOLDOFF`: the hold-off counter increments each cycle. When it reaches `HOLDOFF_CYCLES-1`, go to `IDLE`. Rises during `HOLDOFF` are ignored and not queued.
  - The encoding has no fourth reachable state. Any illegal encoding returns to `IDLE`.
- **`Activate`.** Registered, equal to (state == `FIRE`). It is high for exactly one cycle per accepted press.
- **`SW_FAULT`.** Evaluated each cycle. It blocks only new pulses; it does not cancel a `FIRE` already entered.

## Timing

- **Debounce latency.** Let E0 be the clock edge at which `s1` first samples a new raw level that then holds. The debounced output changes at edge E0+`DEB_CYCLES`+1; with the default of 16, at E0+17.
- **Activate latency.** `Activate` rises at E0+`DEB_CYCLES`+2, 18 cycles with defaults, and falls one edge later.
- **Minimum press spacing.** Pulses are separated by at least `HOLDOFF_CYCLES`+1 cycles between `Activate` rising edges. Each new press also needs a debounced release followed by a debounced press.
- **Simultaneous events.** If the button and both limit switches reach their stable levels on the same edge, `SW_FAULT` is already 1 when `rise` is evaluated, so no pulse is produced.
- **Reset mid-operation.**
  - `Activate` drops immediately when `RST` asserts.
  - A button held through reset release produces exactly one pulse, at E0+`DEB_CYCLES`+2 after release.
  - Limit switches high at reset release reach their outputs one cycle before that pulse can occur.
- **Chatter.** Chatter continuously resets the counter, so a toggling raw input never changes its output.

## Test plan

- **Clean press.** Reset, then `BTN_RAW` = 1 for 40 cycles, then 0 (defaults). Required: `Activate` high for exactly 1 cycle at 18 cycles after the first sampling edge; `Up_MAX` = `Dn_MAX` = 0 throughout.
- **Bounce.** `BTN_RAW` toggles every 3 cycles for 50 cycles, then holds 1. Required: no `Activate` during the toggling; one pulse 18 cycles after the final hold begins.
- **Hold-off.** Press, release for 20 cycles, press again, all within 64 cycles of the first pulse. Required: exactly one pulse. A third press after hold-off expires yields a second pulse.
- **Limit debounce.** `DN_SW_RAW` = 1 held for 15 samples and then dropped. Required: `Dn_MAX` stays 0. Holding it for 16 samples sets `Dn_MAX` = 1 at E0+17, and it clears 17 cycles after release.
- **Fault.** `UP_SW_RAW` = `DN_SW_RAW` = 1 held, then press. Required: `SW_FAULT` = 1 and no `Activate`. Drop `UP_SW_RAW` and press again: one pulse, `SW_FAULT` = 0.
- **Reset mid-press.** Assert `RST` during the `FIRE` cycle. Required: `Activate` drops immediately. With the button still held after release, exactly one pulse follows at 18 cycles.
